// File: rtl/dmac_ioregister_fifo.sv
// dmac_ioregister_fifo
//   Single-clock show-ahead FIFO that feeds the DMAC I/O register's transparent data
//   channel. The head entry is always visible on deq_data while the FIFO is not empty.
//   The FIFO keeps its occupancy in a dedicated counter. Flags are registered from the
//   next-state count, so they are glitch-free and a consumer may tie deq = !empty.
//
// Parameters
//   W_D              data width
//   FIFO_ADDR_WIDTH  log2 of the depth (DEPTH = 2**FIFO_ADDR_WIDTH)
//   ALMOST_MARGIN    almost_full asserts when count >= DEPTH - ALMOST_MARGIN
//
// Ports
//   CLK, RSTN        clock (posedge) and asynchronous active-low reset
//   enq, enq_data    write request and data; the write is dropped when full
//   deq              pop the head entry; the pop is dropped when empty
//   deq_data         head entry, valid whenever !empty
//   full, almost_full, empty, count   occupancy status
//
// Optional feature (macro DMAC_IOREGISTER_FIFO_ERR_EN)
//   overflow, underflow  sticky flags set by a rejected enq or deq
//   err_clr              synchronous clear of both flags; a set in the same cycle wins
module dmac_ioregister_fifo #(
  parameter int unsigned W_D             = 32,
  parameter int unsigned FIFO_ADDR_WIDTH = 4,
  parameter int unsigned ALMOST_MARGIN   = 2
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       enq,
  input  logic [W_D-1:0]             enq_data,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       deq,
  output logic [W_D-1:0]             deq_data,
  output logic                       empty,
`ifdef DMAC_IOREGISTER_FIFO_ERR_EN
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr,
`endif
  output logic [FIFO_ADDR_WIDTH:0]   count
);

  localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned CW    = FIFO_ADDR_WIDTH + 1;

  localparam logic [CW-1:0]              CNT_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0]              CNT_ALMOST = CW'(DEPTH - ALMOST_MARGIN);
  localparam logic [CW-1:0]              CNT_ONE    = CW'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE    = FIFO_ADDR_WIDTH'(1);

  logic [W_D-1:0]             r_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] r_wptr;
  logic [FIFO_ADDR_WIDTH-1:0] r_rptr;
  logic [CW-1:0]              r_count;
  logic                       r_full;
  logic                       r_almost_full;
  logic                       r_empty;

  logic          w_enq_ok;
  logic          w_deq_ok;
  logic [CW-1:0] w_count_next;

  // Acceptance uses the registered (pre-edge) flags, so a full FIFO with enq+deq
  // pops but does not push, and an empty FIFO with enq+deq pushes but does not pop.
  assign w_enq_ok = enq & ~r_full;
  assign w_deq_ok = deq & ~r_empty;

  always_comb begin
    w_count_next = r_count;
    unique case ({w_enq_ok, w_deq_ok})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (w_enq_ok) begin
      r_mem[r_wptr] <= enq_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_empty       <= 1'b1;
    end else begin
      if (w_enq_ok) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_deq_ok) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_count       <= w_count_next;
      r_full        <= (w_count_next == CNT_FULL);
      r_almost_full <= (w_count_next >= CNT_ALMOST);
      r_empty       <= (w_count_next == '0);
    end
  end

  assign deq_data    = r_mem[r_rptr];
  assign count       = r_count;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign empty       = r_empty;

`ifdef DMAC_IOREGISTER_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (enq && r_full) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (deq && r_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_dmac_ioregister_fifo.sv
// Self-checking bench for dmac_ioregister_fifo. A queue-based reference model tracks
// FIFO contents; status and head data are compared after every clock edge.
module tb_dmac_ioregister_fifo;

  localparam int unsigned W_D    = 32;
  localparam int unsigned AW     = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned MARGIN = 2;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          enq = 1'b0;
  logic [W_D-1:0] enq_data = '0;
  logic          full;
  logic          almost_full;
  logic          deq = 1'b0;
  logic [W_D-1:0] deq_data;
  logic          empty;
  logic [AW:0]   count;
`ifdef DMAC_IOREGISTER_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif
  logic          err_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [W_D-1:0] model_q[$];
  logic           m_ovf = 1'b0;
  logic           m_unf = 1'b0;

  dmac_ioregister_fifo #(
    .W_D             (W_D),
    .FIFO_ADDR_WIDTH (AW),
    .ALMOST_MARGIN   (MARGIN)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .enq         (enq),
    .enq_data    (enq_data),
    .full        (full),
    .almost_full (almost_full),
    .deq         (deq),
    .deq_data    (deq_data),
    .empty       (empty),
`ifdef DMAC_IOREGISTER_FIFO_ERR_EN
    .overflow    (overflow),
    .underflow   (underflow),
    .err_clr     (err_clr),
`endif
    .count       (count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W_D-1:0] obs, input logic [W_D-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the reference model.
  task automatic chk_all(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".count"}, W_D'(count), W_D'(sz));
    chk({tag, ".empty"}, W_D'(empty), W_D'(sz == 0));
    chk({tag, ".full"}, W_D'(full), W_D'(sz == DEPTH));
    chk({tag, ".almost_full"}, W_D'(almost_full), W_D'(sz >= DEPTH - MARGIN));
    if (sz != 0) chk({tag, ".deq_data"}, deq_data, model_q[0]);
`ifdef DMAC_IOREGISTER_FIFO_ERR_EN
    chk({tag, ".overflow"}, W_D'(overflow), W_D'(m_ovf));
    chk({tag, ".underflow"}, W_D'(underflow), W_D'(m_unf));
`endif
  endtask

  // One clock with the given request; the model sees the pre-edge occupancy.
  task automatic step(input logic e, input logic [W_D-1:0] d, input logic q, input logic clr,
                      input string tag);
    int  sz;
    logic acc_e, acc_q;
    enq = e; enq_data = d; deq = q; err_clr = clr;
    @(posedge CLK);
    sz    = model_q.size();
    acc_e = e && (sz < DEPTH);
    acc_q = q && (sz > 0);
    if (e && sz == DEPTH) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (q && sz == 0) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    if (acc_q) void'(model_q.pop_front());
    if (acc_e) model_q.push_back(d);
    #1;
    enq = 1'b0; deq = 1'b0; err_clr = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    // Reset then idle.
    #12;
    RSTN = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, "idle");

    // Three enqueues, three dequeues.
    step(1'b1, 32'h11, 1'b0, 1'b0, "enq11");
    step(1'b1, 32'h22, 1'b0, 1'b0, "enq22");
    step(1'b1, 32'h33, 1'b0, 1'b0, "enq33");
    chk("three.count", W_D'(count), 32'd3);
    chk("three.head", deq_data, 32'h11);
    step(1'b0, '0, 1'b1, 1'b0, "deq1");
    chk("deq1.head", deq_data, 32'h22);
    step(1'b0, '0, 1'b1, 1'b0, "deq2");
    chk("deq2.head", deq_data, 32'h33);
    step(1'b0, '0, 1'b1, 1'b0, "deq3");
    chk("deq3.empty", W_D'(empty), 32'd1);

    // Fill to full, overflow attempt, drain in order.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, W_D'(i), 1'b0, 1'b0, "fill");
      if (i == 12) chk("fill13.almost", W_D'(almost_full), 32'd0);
      if (i == 13) chk("fill14.almost", W_D'(almost_full), 32'd1);
      if (i == 14) chk("fill15.full", W_D'(full), 32'd0);
    end
    chk("fill16.full", W_D'(full), 32'd1);
    step(1'b1, 32'hFF, 1'b0, 1'b0, "enq_on_full");
    chk("enq_on_full.count", W_D'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain.order", deq_data, W_D'(i));
      step(1'b0, '0, 1'b1, 1'b0, "drain");
    end

    // Underflow attempt on an empty FIFO, then clear.
    step(1'b0, '0, 1'b1, 1'b0, "deq_on_empty");
    step(1'b0, '0, 1'b0, 1'b0, "uf_hold");
    step(1'b0, '0, 1'b0, 1'b1, "uf_clr");

    // Simultaneous enq+deq at full and at empty.
    for (int i = 0; i < 16; i++) step(1'b1, W_D'(32'h100 + i), 1'b0, 1'b0, "fill2");
    step(1'b1, 32'hDEAD, 1'b1, 1'b0, "both_full");
    chk("both_full.count", W_D'(count), 32'd15);
    chk("both_full.full", W_D'(full), 32'd0);
    while (model_q.size() != 0) step(1'b0, '0, 1'b1, 1'b0, "drain2");
    step(1'b1, 32'hBEEF, 1'b1, 1'b0, "both_empty");
    chk("both_empty.count", W_D'(count), 32'd1);
    chk("both_empty.head", deq_data, 32'hBEEF);

    // Randomised interleave with wrap-around.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 9) == 0), "rand");
    end

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, "pre_rst");
    #2;
    RSTN = 1'b0;
    #1;
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk("async_rst.empty", W_D'(empty), 32'd1);
    chk("async_rst.count", W_D'(count), 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK); #1;
    chk_all("post_rst");
    step(1'b1, 32'hA5, 1'b0, 1'b0, "enqA5");
    chk("enqA5.head", deq_data, 32'hA5);
    step(1'b0, '0, 1'b1, 1'b0, "deqA5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
